pe_arrays: RTL and testbench
============================

PE_ARRAYS -- requirements
Module: pe_arrays

Interface
REQ-001 The block SHALL have parameter Data_width, default 8, giving the width of each weight, ifmap and psum element.
REQ-002 The block SHALL have parameter WORD_SIZE, default 72, equal to 9*Data_width, giving the packed weight/ifmap bus width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports iClk and iRest_n.
REQ-004 iClk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 iRest_n  input  1  SHALL be the synchronous, active-high reset.
REQ-006 enable_w  input  1  SHALL be the weight-load enable.
REQ-007 Run  input  1  SHALL be the compute enable for ifmap and psum pipeline registers.
REQ-008 Weight_f_top  input  WORD_SIZE  SHALL carry nine packed weights; byte k (k=1..9) = bits [WORD_SIZE-1-(k-1)*Data_width -: Data_width], PE1 at the MSB byte.
REQ-009 Ifmap_f_left_1..Ifmap_f_left_9  input  Data_width each  SHALL be the ifmap operand for PE1..PE9.
REQ-010 Psum_t_down  output  Data_width  SHALL be the registered partial sum of PE9 (bottom of column).
REQ-011 Ifmap_t_right  output  WORD_SIZE  SHALL be the nine registered ifmaps, packed with the same byte order as Weight_f_top (PE1 at MSB).

Function
REQ-012 The block SHALL be a weight-stationary column of nine PEs, PE1 (top) to PE9 (bottom); psum flows down, ifmap flows right.
REQ-013 Each PE k SHALL hold a Data_width weight register w[k], an ifmap register x[k] and a psum register p[k].
REQ-014 On a rising edge with reset low and enable_w=1, w[k] SHALL load byte k of Weight_f_top; with enable_w=0, w[k] SHALL hold.
REQ-015 On a rising edge with reset low and Run=1, x[k] SHALL load Ifmap_f_left_k.
REQ-016 On the same edge, p[k] SHALL load p[k-1] + w[k]*Ifmap_f_left_k, using the w[k] value before the edge, with p[0] defined as 0.
REQ-017 Arithmetic SHALL be unsigned; product and sum SHALL be truncated to the low Data_width bits (modulo 2^Data_width), with no saturation and no overflow flag.
REQ-018 With Run=0, x[k] and p[k] SHALL hold their values; weight loading per REQ-014 SHALL remain independent of Run.
REQ-019 Psum_t_down SHALL equal p[9]; Ifmap_t_right SHALL equal {x[1],...,x[9]}; both SHALL be direct register outputs with no combinational path from inputs.
REQ-020 For a dot product, operand k SHALL be presented on Ifmap_f_left_k one cycle after operand k-1 (diagonal skew); the result SHALL appear on Psum_t_down after the edge that samples Ifmap_f_left_9, i.e. 9 cycles after operand 1 is sampled.
REQ-021 A weight loaded on edge t SHALL first be used in the multiply at edge t+1.
REQ-022 Back-to-back skewed vectors SHALL be accepted one per cycle with no bubbles while Run=1.

Reset
REQ-023 On a rising edge with iRest_n=1, all w[k], x[k] and p[k] SHALL clear to 0, so Psum_t_down=0 and Ifmap_t_right=0, regardless of enable_w and Run.
REQ-024 Reset SHALL take priority over weight load and compute on the same edge; asserting reset mid-computation SHALL discard all in-flight partial sums.
REQ-025 Outputs SHALL be undefined only before the first reset edge; one reset edge SHALL fully initialise the block.

Verification
REQ-026 Reset: iRest_n=1 for one edge with Run=1 and enable_w=1 -> Psum_t_down=0 and Ifmap_t_right=0 after that edge.
REQ-027 Weights all 1, enable_w=1, Run=1; Ifmap_f_left_k set to 1 at cycle k (skewed) and held -> Psum_t_down steps 1..9, reaching 9 after the edge sampling Ifmap_f_left_9, and stays 9.
REQ-028 Weights PE1..PE9 = 1..9, single skewed vector with all operands = 2, other cycles 0 -> Psum_t_down = 90 exactly once, 9 cycles after operand 1.
REQ-029 Overflow: all weights 255, all skewed operands 255 -> each product truncates to 1 -> Psum_t_down = 9.
REQ-030 Passthrough and hold: Ifmap_f_left_k = k with Run=1 -> Ifmap_t_right = 0x010203040506070809 after one edge; then Run=0 with changed inputs -> Ifmap_t_right and Psum_t_down unchanged.
REQ-031 Weight retention: load weights all 1, then enable_w=0 with Weight_f_top=0 -> the REQ-027 stimulus still yields 9.

Source files
------------

// File: rtl/pe_arrays.sv
// pe_arrays: weight-stationary column of nine processing elements.
//   PE1 sits at the top and PE9 at the bottom. Partial sums flow down the
//   column and ifmaps flow out to the right.
//   Each PE k keeps three registers: a weight w[k], an ifmap x[k] and a
//   partial sum p[k]. On every Run cycle it computes
//     p[k] <= p[k-1] + w[k]*ifmap_k
//   All arithmetic is unsigned and wraps modulo 2^Data_width.
//   To form a dot product, the caller skews the operands diagonally:
//   operand k arrives one cycle after operand k-1.
//
// Ports
//   iClk            clock, rising edge
//   iRest_n         synchronous reset, active HIGH (clears w, x, p)
//   enable_w        load all nine weights from Weight_f_top
//   Run             advance the ifmap and psum registers
//   Weight_f_top    nine packed weights, PE1 in the MSB byte
//   Ifmap_f_left_k  ifmap operand for PE k (k = 1..9)
//   Psum_t_down     registered psum of PE9
//   Ifmap_t_right   nine registered ifmaps, PE1 in the MSB byte
module pe_arrays #(
   parameter int Data_width = 8,
   parameter int WORD_SIZE  = 72
) (
   input  logic                  iClk,
   input  logic                  iRest_n,
   input  logic                  enable_w,
   input  logic                  Run,
   input  logic [WORD_SIZE-1:0]  Weight_f_top,
   input  logic [Data_width-1:0] Ifmap_f_left_1,
   input  logic [Data_width-1:0] Ifmap_f_left_2,
   input  logic [Data_width-1:0] Ifmap_f_left_3,
   input  logic [Data_width-1:0] Ifmap_f_left_4,
   input  logic [Data_width-1:0] Ifmap_f_left_5,
   input  logic [Data_width-1:0] Ifmap_f_left_6,
   input  logic [Data_width-1:0] Ifmap_f_left_7,
   input  logic [Data_width-1:0] Ifmap_f_left_8,
   input  logic [Data_width-1:0] Ifmap_f_left_9,
   output logic [Data_width-1:0] Psum_t_down,
   output logic [WORD_SIZE-1:0]  Ifmap_t_right
);
   localparam int NUM_PE = 9;

   // Lane i corresponds to PE(i+1); lane 0 is the top of the column.
   logic [NUM_PE-1:0][Data_width-1:0] x_in, w_in;
   logic [NUM_PE-1:0][Data_width-1:0] w_q, x_q, p_q;
   logic [NUM_PE-1:0][Data_width-1:0] p_above, prod, mac;

   assign x_in = {Ifmap_f_left_9, Ifmap_f_left_8, Ifmap_f_left_7,
                  Ifmap_f_left_6, Ifmap_f_left_5, Ifmap_f_left_4,
                  Ifmap_f_left_3, Ifmap_f_left_2, Ifmap_f_left_1};

   genvar i;
   generate
      for (i = 0; i < NUM_PE; i++) begin : g_lane
         assign w_in[i] = Weight_f_top[WORD_SIZE-1-i*Data_width -: Data_width];
         assign Ifmap_t_right[WORD_SIZE-1-i*Data_width -: Data_width] = x_q[i];

         // The top PE has no neighbour above, so its incoming psum is zero.
         if (i == 0) begin : g_top
            assign p_above[i] = '0;
         end else begin : g_mid
            assign p_above[i] = p_q[i-1];
         end

         // Narrow destinations give modulo-2^Data_width wrap: no saturation.
         // The multiply uses the live ifmap input and the weight as it was
         // before this edge, so a new weight takes effect one edge later.
         assign prod[i] = w_q[i] * x_in[i];
         assign mac[i]  = p_above[i] + prod[i];
      end
   endgenerate

   // Reset outranks everything. The weight load does not depend on Run.
   always_ff @(posedge iClk) begin
      if (iRest_n) begin
         w_q <= '0;
         x_q <= '0;
         p_q <= '0;
      end else begin
         if (enable_w) w_q <= w_in;
         if (Run) begin
            x_q <= x_in;
            p_q <= mac;
         end
      end
   end

   assign Psum_t_down = p_q[NUM_PE-1];
endmodule

// File: tb/tb_pe_arrays.sv
module tb_pe_arrays;
   localparam int DW = 8;
   localparam int WS = 72;

   logic          clk = 1'b0;
   logic          rst, enw, run;
   logic [WS-1:0] wtop;
   logic [DW-1:0] ifm [1:9];
   logic [DW-1:0] psum;
   logic [WS-1:0] xr;

   pe_arrays #(.Data_width(DW), .WORD_SIZE(WS)) dut (
      .iClk(clk), .iRest_n(rst), .enable_w(enw), .Run(run),
      .Weight_f_top(wtop),
      .Ifmap_f_left_1(ifm[1]), .Ifmap_f_left_2(ifm[2]), .Ifmap_f_left_3(ifm[3]),
      .Ifmap_f_left_4(ifm[4]), .Ifmap_f_left_5(ifm[5]), .Ifmap_f_left_6(ifm[6]),
      .Ifmap_f_left_7(ifm[7]), .Ifmap_f_left_8(ifm[8]), .Ifmap_f_left_9(ifm[9]),
      .Psum_t_down(psum), .Ifmap_t_right(xr)
   );

   always #5 clk = ~clk;

   // cyc holds the number of rising edges seen so far.
   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      int            at;
      bit            cp;
      logic [DW-1:0] p;
      bit            cx;
      logic [WS-1:0] x;
      string         name;
   } exp_t;
   exp_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [WS-1:0] X_ONES = 72'h010101010101010101;
   localparam logic [WS-1:0] X_SEQ  = 72'h010203040506070809;

   task automatic push(input int at, input bit cp, input logic [DW-1:0] p,
                       input bit cx, input logic [WS-1:0] x, input string name);
      exp_t e;
      e.at = at; e.cp = cp; e.p = p; e.cx = cx; e.x = x; e.name = name;
      sb.push_back(e);
   endtask

   // The monitor samples on the falling edge, away from input changes.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at < cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: expectation for edge %0d never sampled (now %0d)",
                     sb[i].name, sb[i].at, cyc);
            sb.delete(i);
         end else if (sb[i].at == cyc) begin
            if (sb[i].cp) begin
               n_cmp++;
               if (psum !== sb[i].p) begin
                  n_bad++;
                  $display("FAIL %s psum @edge %0d: got %0d want %0d",
                           sb[i].name, cyc, psum, sb[i].p);
               end
            end
            if (sb[i].cx) begin
               n_cmp++;
               if (xr !== sb[i].x) begin
                  n_bad++;
                  $display("FAIL %s ifmap @edge %0d: got %h want %h",
                           sb[i].name, cyc, xr, sb[i].x);
               end
            end
            sb.delete(i);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WS-1:0] wpack(input int base, input int step);
      logic [WS-1:0] v;
      v = '0;
      for (int k = 1; k <= 9; k++) v[WS-1-(k-1)*DW -: DW] = DW'(base + step*(k-1));
      return v;
   endfunction

   task automatic ifm_all(input logic [DW-1:0] v);
      for (int k = 1; k <= 9; k++) ifm[k] = v;
   endtask

   // Skewed drive: at relative cycle c, PE k gets vector (c-k+1).
   // With held=1, PE k is driven with 1 from cycle k-1 onward.
   logic [DW-1:0] vecs [0:3][1:9];
   int  nvec;
   bit  held;
   task automatic skew(input int c0, input int c1);
      for (int c = c0; c <= c1; c++) begin
         for (int k = 1; k <= 9; k++) begin
            int v;
            v = c - (k - 1);
            if (held)                     ifm[k] = (v >= 0) ? 8'd1 : 8'd0;
            else if (v >= 0 && v < nvec)  ifm[k] = vecs[v][k];
            else                          ifm[k] = 8'd0;
         end
         tick;
      end
   endtask

   task automatic set_vec(input int v, input logic [DW-1:0] val);
      for (int k = 1; k <= 9; k++) vecs[v][k] = val;
   endtask

   task automatic do_reset;
      rst = 1'b1; tick; rst = 1'b0;
   endtask

   initial begin
      int s;
      // One reset edge with Run and enable_w both high must clear everything.
      rst = 1'b1; run = 1'b1; enw = 1'b1; wtop = '1; ifm_all(8'h5A);
      push(cyc + 1, 1, 8'd0, 1, '0, "reset");
      tick;

      // Weights all 1, held-ones skewed stimulus: 9 at the 9th edge, then holds.
      rst = 1'b0; wtop = wpack(1, 0); ifm_all(8'd0);
      tick;
      held = 1'b1; s = cyc + 1;
      push(s + 8, 1, 8'd9, 1, X_ONES, "held_ones");
      push(s + 9, 1, 8'd9, 0, '0, "held_ones_stay1");
      push(s + 10, 1, 8'd9, 0, '0, "held_ones_stay2");
      skew(0, 10);
      held = 1'b0;

      // Weights 1..9 with a single vector of 2s: 90 shows up exactly once.
      do_reset;
      wtop = wpack(1, 1); ifm_all(8'd0);
      tick;
      nvec = 1; set_vec(0, 8'd2); s = cyc + 1;
      push(s + 7, 1, 8'd0, 0, '0, "dot_before");
      push(s + 8, 1, 8'd90, 0, '0, "dot_result");
      push(s + 9, 1, 8'd0, 0, '0, "dot_after");
      skew(0, 10);

      // Back-to-back vectors with no bubble: 45 and then 90.
      nvec = 2; set_vec(0, 8'd1); set_vec(1, 8'd2); s = cyc + 1;
      push(s + 8, 1, 8'd45, 0, '0, "b2b_first");
      push(s + 9, 1, 8'd90, 0, '0, "b2b_second");
      push(s + 10, 1, 8'd0, 0, '0, "b2b_drain");
      skew(0, 10);

      // Overflow: 255*255 wraps to 1, and nine of those sum to 9.
      do_reset;
      wtop = wpack(255, 0); ifm_all(8'd0);
      tick;
      nvec = 1; set_vec(0, 8'd255); s = cyc + 1;
      push(s + 8, 1, 8'd9, 0, '0, "overflow");
      skew(0, 9);

      // Ifmap passthrough, followed by a hold while Run=0.
      do_reset;
      wtop = wpack(1, 0); ifm_all(8'd0);
      tick;
      enw = 1'b0; wtop = '0;
      for (int k = 1; k <= 9; k++) ifm[k] = DW'(k);
      push(cyc + 1, 1, 8'd9, 1, X_SEQ, "passthrough");
      tick;
      run = 1'b0; ifm_all(8'hAA);
      push(cyc + 1, 1, 8'd9, 1, X_SEQ, "hold1");
      tick;
      push(cyc + 1, 1, 8'd9, 1, X_SEQ, "hold2");
      tick;
      // Weights load while Run=0; x and p stay where they were.
      enw = 1'b1; wtop = wpack(3, 0);
      push(cyc + 1, 1, 8'd9, 1, X_SEQ, "wload_run0_hold");
      tick;
      // First compute edge after that: p9 = p8 (8) + 3*1 = 11.
      enw = 1'b0; wtop = '0; run = 1'b1; ifm_all(8'd1);
      push(cyc + 1, 1, 8'd11, 1, X_ONES, "wload_run0_used");
      tick;

      // Weight retention: load 1s, then enable_w=0 with Weight_f_top=0.
      do_reset;
      run = 1'b0; enw = 1'b1; wtop = wpack(1, 0); ifm_all(8'd0);
      tick;
      enw = 1'b0; wtop = '0; run = 1'b1;
      held = 1'b1; s = cyc + 1;
      push(s + 8, 1, 8'd9, 0, '0, "retention");
      skew(0, 8);
      held = 1'b0;

      // A reset mid-vector throws away in-flight sums and the weights.
      nvec = 1; set_vec(0, 8'd5); s = cyc + 1;
      skew(0, 3);
      rst = 1'b1;
      for (int k = 1; k <= 9; k++) ifm[k] = (k == 5) ? 8'd5 : 8'd0;
      push(cyc + 1, 1, 8'd0, 1, '0, "mid_reset");
      tick;
      rst = 1'b0;
      push(s + 8, 1, 8'd0, 0, '0, "mid_reset_discard");
      skew(5, 9);

      // Give the monitor a bounded amount of time to drain the queue.
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick;
      if (sb.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
